// File: rtl/ram_port_arb.sv
// Round-robin arbiter merging two bus hosts onto one 1-cycle-latency RAM port.
// Define RAM_PORT_ARB_ZERO_INIT_EN to zero-fill the RAM after reset before serving hosts.
module ram_port_arb #(
    parameter int unsigned Depth    = 128,
    parameter logic [31:0] BaseAddr = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        h0_req_i,
    output logic        h0_gnt_o,
    input  logic        h0_we_i,
    input  logic [3:0]  h0_be_i,
    input  logic [31:0] h0_addr_i,
    input  logic [31:0] h0_wdata_i,
    output logic        h0_rvalid_o,
    output logic [31:0] h0_rdata_o,
    input  logic        h1_req_i,
    output logic        h1_gnt_o,
    input  logic        h1_we_i,
    input  logic [3:0]  h1_be_i,
    input  logic [31:0] h1_addr_i,
    input  logic [31:0] h1_wdata_i,
    output logic        h1_rvalid_o,
    output logic [31:0] h1_rdata_o,
    output logic        ram_req_o,
    output logic        ram_we_o,
    output logic [3:0]  ram_be_o,
    output logic [31:0] ram_addr_o,
    output logic [31:0] ram_wdata_o,
    input  logic        ram_rvalid_i,
    input  logic [31:0] ram_rdata_i,
    output logic        init_done_o
);

    logic run;
    logic init_act;
    logic last_q;
    logic own_vld_q;
    logic own_q;

`ifdef RAM_PORT_ARB_ZERO_INIT_EN
    localparam int unsigned CntW = (Depth > 1) ? $clog2(Depth) : 1;

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_e;

    state_e            state_q;
    logic [CntW-1:0]   cnt_q;
    logic              init_done_q;
    logic [31:0]       init_addr;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_INIT;
            cnt_q       <= '0;
            init_done_q <= 1'b0;
        end else begin
            unique case (state_q)
                ST_INIT: begin
                    cnt_q <= cnt_q + CntW'(1);
                    if (cnt_q == CntW'(Depth - 1)) begin
                        state_q     <= ST_RUN;
                        init_done_q <= 1'b1;
                    end
                end
                ST_RUN: ;
                default: state_q <= ST_INIT;
            endcase
        end
    end

    assign run         = (state_q == ST_RUN);
    assign init_act    = (state_q == ST_INIT);
    assign init_addr   = BaseAddr + (32'(cnt_q) << 2);
    assign init_done_o = init_done_q;
`else
    logic unused_cfg;
    assign unused_cfg  = ^{BaseAddr, Depth};
    assign run         = 1'b1;
    assign init_act    = 1'b0;
    assign init_done_o = 1'b1;
`endif

    // On contention the host that did not win last time gets the port
    assign h0_gnt_o = run & h0_req_i & (~h1_req_i | last_q);
    assign h1_gnt_o = run & h1_req_i & (~h0_req_i | ~last_q);

    always_comb begin
        ram_req_o   = h0_gnt_o | h1_gnt_o;
        ram_we_o    = 1'b0;
        ram_be_o    = 4'h0;
        ram_addr_o  = 32'h0;
        ram_wdata_o = 32'h0;
        unique case (1'b1)
`ifdef RAM_PORT_ARB_ZERO_INIT_EN
            init_act: begin
                ram_req_o  = 1'b1;
                ram_we_o   = 1'b1;
                ram_be_o   = 4'hF;
                ram_addr_o = init_addr;
            end
`endif
            h0_gnt_o: begin
                ram_we_o    = h0_we_i;
                ram_be_o    = h0_be_i;
                ram_addr_o  = h0_addr_i;
                ram_wdata_o = h0_wdata_i;
            end
            h1_gnt_o: begin
                ram_we_o    = h1_we_i;
                ram_be_o    = h1_be_i;
                ram_addr_o  = h1_addr_i;
                ram_wdata_o = h1_wdata_i;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_q    <= 1'b1;
            own_vld_q <= 1'b0;
            own_q     <= 1'b0;
        end else begin
            own_vld_q <= h0_gnt_o | h1_gnt_o;
            own_q     <= h1_gnt_o;
            if (h0_gnt_o) begin
                last_q <= 1'b0;
            end else if (h1_gnt_o) begin
                last_q <= 1'b1;
            end
        end
    end

    // Init-sweep and stray responses never reach a host: own_vld_q is clear
    assign h0_rvalid_o = ram_rvalid_i & own_vld_q & ~own_q;
    assign h1_rvalid_o = ram_rvalid_i & own_vld_q & own_q;
    assign h0_rdata_o  = h0_rvalid_o ? ram_rdata_i : 32'h0;
    assign h1_rdata_o  = h1_rvalid_o ? ram_rdata_i : 32'h0;

    logic unused_init;
    assign unused_init = init_act & 1'b0;

endmodule

// File: tb/tb_ram_port_arb.sv
// Directed bench for ram_port_arb with a 1-cycle RAM response model.
module tb_ram_port_arb;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic        h0_req, h0_gnt, h0_we, h0_rvalid;
    logic [3:0]  h0_be;
    logic [31:0] h0_addr, h0_wdata, h0_rdata;
    logic        h1_req, h1_gnt, h1_we, h1_rvalid;
    logic [3:0]  h1_be;
    logic [31:0] h1_addr, h1_wdata, h1_rdata;
    logic        ram_req, ram_we, ram_rvalid, init_done;
    logic [3:0]  ram_be;
    logic [31:0] ram_addr, ram_wdata, ram_rdata;

    logic        rv_q = 1'b0;
    logic [31:0] rd_q = 32'h0;
    logic        stray;
    logic [31:0] resp_data;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        rv_q <= ram_req;
        if (ram_req) rd_q <= resp_data;
    end

    assign ram_rvalid = rv_q | stray;
    assign ram_rdata  = rd_q;

    ram_port_arb #(
        .Depth    (8),
        .BaseAddr (32'h0010_0000)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_ni),
        .h0_req_i     (h0_req),
        .h0_gnt_o     (h0_gnt),
        .h0_we_i      (h0_we),
        .h0_be_i      (h0_be),
        .h0_addr_i    (h0_addr),
        .h0_wdata_i   (h0_wdata),
        .h0_rvalid_o  (h0_rvalid),
        .h0_rdata_o   (h0_rdata),
        .h1_req_i     (h1_req),
        .h1_gnt_o     (h1_gnt),
        .h1_we_i      (h1_we),
        .h1_be_i      (h1_be),
        .h1_addr_i    (h1_addr),
        .h1_wdata_i   (h1_wdata),
        .h1_rvalid_o  (h1_rvalid),
        .h1_rdata_o   (h1_rdata),
        .ram_req_o    (ram_req),
        .ram_we_o     (ram_we),
        .ram_be_o     (ram_be),
        .ram_addr_o   (ram_addr),
        .ram_wdata_o  (ram_wdata),
        .ram_rvalid_i (ram_rvalid),
        .ram_rdata_i  (ram_rdata),
        .init_done_o  (init_done)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_ni = 1'b0; stray = 1'b0; resp_data = 32'h0;
        h0_req = 0; h0_we = 0; h0_be = 0; h0_addr = 0; h0_wdata = 0;
        h1_req = 0; h1_we = 0; h1_be = 0; h1_addr = 0; h1_wdata = 0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_h0_rvalid", 32'(h0_rvalid), 32'd0);
        chk("rst_h1_rvalid", 32'(h1_rvalid), 32'd0);
        chk("rst_ram_req", 32'(ram_req), 32'd0);
        chk("rst_h0_gnt", 32'(h0_gnt), 32'd0);
`ifdef RAM_PORT_ARB_ZERO_INIT_EN
        chk("rst_init_done", 32'(init_done), 32'd0);
`else
        chk("rst_init_done", 32'(init_done), 32'd1);
        h1_req = 1'b1;
        #1;
        chk("rst_h1_gnt", 32'(h1_gnt), 32'd1);
        chk("rst_ram_req_follow", 32'(ram_req), 32'd1);
        h1_req = 1'b0;
`endif
        @(negedge clk);
        rst_ni = 1'b1;

`ifdef RAM_PORT_ARB_ZERO_INIT_EN
        h0_req = 1'b1; h1_req = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            chk("init_h0_gnt", 32'(h0_gnt), 32'd0);
            chk("init_h1_gnt", 32'(h1_gnt), 32'd0);
            chk("init_ram_req", 32'(ram_req), 32'd1);
            chk("init_ram_we", 32'(ram_we), 32'd1);
            chk("init_ram_be", 32'(ram_be), 32'hF);
            chk("init_ram_addr", ram_addr, 32'h0010_0000 + 32'(i * 4));
            chk("init_ram_wdata", ram_wdata, 32'h0);
            chk("init_done_low", 32'(init_done), 32'd0);
            chk("init_h0_rvalid", 32'(h0_rvalid), 32'd0);
            chk("init_h1_rvalid", 32'(h1_rvalid), 32'd0);
            @(negedge clk);
        end
        #1;
        chk("init_done_high", 32'(init_done), 32'd1);
`endif

        // Contention straight after reset: h0 first, then alternate
        for (int k = 0; k < 5; k++) begin
            h0_req = (k < 4); h1_req = (k < 4);
            h0_addr = 32'h40; h1_addr = 32'h80;
            resp_data = 32'h1000 + 32'(k);
            #1;
            if (k < 4) begin
                chk("rr_h0_gnt", 32'(h0_gnt), 32'((k % 2) == 0));
                chk("rr_h1_gnt", 32'(h1_gnt), 32'((k % 2) == 1));
            end
            chk("rr_h0_rvalid", 32'(h0_rvalid), 32'((k > 0) && ((k % 2) == 1)));
            chk("rr_h1_rvalid", 32'(h1_rvalid), 32'((k > 0) && ((k % 2) == 0)));
            if (k > 0) begin
                chk("rr_rdata", (k % 2 == 1) ? h0_rdata : h1_rdata,
                    32'h1000 + 32'(k - 1));
            end
            @(negedge clk);
        end

        // h0 read alone
        h0_req = 1'b1; h0_we = 1'b0; h0_be = 4'hF; h0_addr = 32'h10;
        resp_data = 32'hDEAD_BEEF;
        #1;
        chk("rd_h0_gnt", 32'(h0_gnt), 32'd1);
        chk("rd_h1_gnt", 32'(h1_gnt), 32'd0);
        chk("rd_ram_req", 32'(ram_req), 32'd1);
        chk("rd_ram_addr", ram_addr, 32'h10);
        chk("rd_ram_we", 32'(ram_we), 32'd0);
        @(negedge clk);
        h0_req = 1'b0;
        #1;
        chk("rd_h0_rvalid", 32'(h0_rvalid), 32'd1);
        chk("rd_h0_rdata", h0_rdata, 32'hDEAD_BEEF);
        chk("rd_h1_rvalid", 32'(h1_rvalid), 32'd0);
        chk("rd_h1_rdata", h1_rdata, 32'h0);

        // h1 write
        @(negedge clk);
        h1_req = 1'b1; h1_we = 1'b1; h1_be = 4'b0011;
        h1_addr = 32'h20; h1_wdata = 32'h1234_5678;
        resp_data = 32'h0BAD_F00D;
        #1;
        chk("wr_h1_gnt", 32'(h1_gnt), 32'd1);
        chk("wr_ram_we", 32'(ram_we), 32'd1);
        chk("wr_ram_be", 32'(ram_be), 32'h3);
        chk("wr_ram_addr", ram_addr, 32'h20);
        chk("wr_ram_wdata", ram_wdata, 32'h1234_5678);
        @(negedge clk);
        h1_req = 1'b0;
        #1;
        chk("wr_h1_rvalid", 32'(h1_rvalid), 32'd1);
        chk("wr_h0_rvalid", 32'(h0_rvalid), 32'd0);
        chk("idle_ram_req", 32'(ram_req), 32'd0);
        chk("idle_ram_we", 32'(ram_we), 32'd0);
        chk("idle_ram_be", 32'(ram_be), 32'd0);
        chk("idle_ram_addr", ram_addr, 32'h0);
        chk("idle_ram_wdata", ram_wdata, 32'h0);

        // Stray RAM response with nothing outstanding
        @(negedge clk);
        stray = 1'b1;
        #1;
        chk("stray_h0_rvalid", 32'(h0_rvalid), 32'd0);
        chk("stray_h1_rvalid", 32'(h1_rvalid), 32'd0);
        chk("stray_h0_rdata", h0_rdata, 32'h0);
        stray = 1'b0;

        // Reset one cycle after an h0 grant drops its response
        @(negedge clk);
        h0_req = 1'b1; h0_we = 1'b0; h0_addr = 32'h44;
        #1;
        chk("rstmid_h0_gnt", 32'(h0_gnt), 32'd1);
        @(negedge clk);
        h0_req = 1'b0; rst_ni = 1'b0;
        #1;
        chk("rstmid_h0_rvalid", 32'(h0_rvalid), 32'd0);
        @(negedge clk);
        rst_ni = 1'b1;
        #1;
        chk("rstrel_h0_rvalid", 32'(h0_rvalid), 32'd0);
`ifdef RAM_PORT_ARB_ZERO_INIT_EN
        repeat (8) @(negedge clk);
        #1;
        chk("reinit_done", 32'(init_done), 32'd1);
`endif
        h0_req = 1'b1; h1_req = 1'b1;
        #1;
        chk("post_rst_h0_gnt", 32'(h0_gnt), 32'd1);
        chk("post_rst_h1_gnt", 32'(h1_gnt), 32'd0);
        @(negedge clk);
        h0_req = 1'b0; h1_req = 1'b0;
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
